riscv_lsu: RTL

//  Load/store unit between the core's MEM stage and data memory. Replaces the word-only direct memory strobes.

---
 rtl/riscv_lsu_pkg.sv | 42 ++++
 rtl/riscv_lsu_lane_align.sv | 47 ++++
 rtl/riscv_lsu.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
// Access sizes follow the RV32I funct3 encoding.
package riscv_lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP,
    HALTED
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic is_legal_access(
    input logic       we,
    input logic [2:0] funct3,
    input logic [1:0] addr_lo
  );
    logic f3_ok;
    logic al_ok;
    if (we)
      f3_ok = funct3 inside {F3_SB, F3_SH, F3_SW};
    else
      f3_ok = funct3 inside {F3_LB, F3_LH, F3_LW,
                             F3_LBU, F3_LHU};
    case (funct3[1:0])
      2'b01:   al_ok = ~addr_lo[0];
      2'b10:   al_ok = (addr_lo == 2'b00);
      default: al_ok = 1'b1;
    endcase
    return f3_ok & al_ok;
  endfunction

endpackage

// File: rtl/riscv_lsu_lane_align.sv
// Byte-lane steering: store enables/replication and load
// lane select with sign or zero extension.
module lsu_lane_align
  import riscv_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]          funct3_i,
  input  logic [1:0]          addr_lo_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W-1:0]   rdata_i,
  output logic [DATA_W/8-1:0] be_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] sh;

  assign sh = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    be_o    = '1;
    wdata_o = wdata_i;
    rdata_o = sh;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = NB'(1) << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = NB'(3) << addr_lo_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
    case (funct3_i)
      F3_LB:   rdata_o = {{24{sh[7]}}, sh[7:0]};
      F3_LH:   rdata_o = {{16{sh[15]}}, sh[15:0]};
      F3_LBU:  rdata_o = {24'd0, sh[7:0]};
      F3_LHU:  rdata_o = {16'd0, sh[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one outstanding access, fixed read
// latency, error screening and halt drain.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [DATA_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic                resp_err,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                stall,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                halt_req,
  output logic                halt_done
);

  localparam int CW = $clog2(MEM_LAT + 1);

  if (DATA_W != 32) begin : g_bad_width
    $error("riscv_lsu: DATA_W must be 32");
  end
  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("riscv_lsu: MEM_LAT must be 1..4");
  end

  lsu_state_e          state_q;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CW-1:0]       cnt_q;
  logic                mem_rd_q;
  logic                mem_wr_q;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                halt_pend_q;
  logic                halt_done_q;

  logic                req_err;
  logic [DATA_W/8-1:0] be_w;
  logic [DATA_W-1:0]   wdata_w;
  logic [DATA_W-1:0]   ld_w;

  assign req_err = ~is_legal_access(req_we, req_funct3,
                                    req_addr[1:0])
                 | (|req_addr[DATA_W-1:ADDR_W+2]);

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .funct3_i  (f3_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (mem_rdata),
    .be_o      (be_w),
    .wdata_o   (wdata_w),
    .rdata_o   (ld_w)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      f3_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      halt_pend_q  <= 1'b0;
      halt_done_q  <= 1'b0;
    end else begin
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      if (halt_req && state_q != IDLE && state_q != HALTED)
        halt_pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (halt_req) begin
            state_q     <= HALTED;
            halt_done_q <= 1'b1;
          end else if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr[ADDR_W+1:0];
            wdata_q <= req_wdata;
            if (req_err) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q  <= ACCESS;
              mem_rd_q <= ~req_we;
              mem_wr_q <= req_we;
            end
          end
        end
        ACCESS: begin
          if (we_q) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
          end else begin
            state_q <= WAIT;
            cnt_q   <= CW'(MEM_LAT - 1);
          end
        end
        WAIT: begin
          // cnt_q reaches zero in the cycle mem_rdata is valid
          if (cnt_q == '0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= ld_w;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RESP: begin
          if (halt_pend_q || halt_req) begin
            state_q     <= HALTED;
            halt_done_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        HALTED: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE) & ~halt_req;
  assign stall      = (state_q != IDLE);
  assign mem_rd     = mem_rd_q & ~reset;
  assign mem_wr     = mem_wr_q & ~reset;
  assign mem_addr   = addr_q[ADDR_W+1:2];
  assign mem_be     = mem_wr_q ? be_w : '0;
  assign mem_wdata  = mem_wr_q ? wdata_w : '0;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign halt_done  = halt_done_q;

endmodule
